uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. It supports 5-9 data bits, optional odd or even parity, and 1 or 2 stop bits. It adds parity-error, framing-error and break detection, plus an asynchronous active-low reset. It sits between the board RX pin and the command/feedback parser, and delivers one word plus status flags per frame.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (i_Clock freq / baud); legal range 8..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
i_Clock  in  1  system clock, rising edge
i_Rst_L  in  1  asynchronous active-low reset
i_Rx_Serial  in  1  asynchronous serial line, idle high
o_Rx_DV  out  1  one-cycle pulse: frame complete, word and flags valid
o_Rx_Byte  out  DATA_BITS  received word, LSB first on the line; held until next o_Rx_DV
o_Parity_Err  out  1  parity mismatch for the frame; valid with o_Rx_DV, held until next o_Rx_DV
o_Frame_Err  out  1  a stop-bit sample was 0; valid with o_Rx_DV, held
o_Break  out  1  break detected; valid with o_Rx_DV, held

Behaviour:
- Reset (async assert, sync release): both synchroniser flops = 1, state = IDLE, counters = 0, all outputs = 0.
- Input passes a 2-flop synchroniser; all sampling below uses the synchronised line (rx_s).
- Bit counter width is $clog2(CLKS_PER_BIT)+1. Counter resets to 0 on every sample point.
- IDLE: clear counters; when rx_s == 0, go to START.
- START: count up to (CLKS_PER_BIT-1)/2.
  - At that count, rx_s == 0: clear counter, go to DATA.
  - At that count, rx_s == 1: false start; go to IDLE with no DV and no flags changed.
- DATA: sample rx_s when count == CLKS_PER_BIT-1 into bit index 0..DATA_BITS-1.
  - After the last bit, go to PAR if PARITY != 0, else STOP.
- PAR: sample the parity bit after CLKS_PER_BIT-1 cycles.
  - Error if XOR of the data bits and the parity bit is 0 for odd, or 1 for even.
  - Go to STOP.
- STOP: sample STOP_BITS stop bits, each after CLKS_PER_BIT-1 cycles. Any sample == 0 sets frame error.
- On the cycle after the final stop sample:
  - o_Rx_DV = 1 for exactly one cycle.
  - o_Rx_Byte, o_Parity_Err, o_Frame_Err and o_Break are updated in that same cycle.
  - o_Parity_Err = 0 when PARITY == 0.
- Break: all data bits, the parity bit (if present) and all stop samples are 0. Then o_Break = 1 and o_Frame_Err = 1.
- After DV:
  - No frame error: go to IDLE. A new start bit may begin the next cycle; no CLEANUP dwell.
  - Frame error: go to WAIT_HIGH. Stay there until rx_s == 1, then go to IDLE. No new frame starts while the line is held low.
- Latency: sample points sit at mid-bit. o_Rx_DV asserts 1 + 2 (sync) + (CLKS_PER_BIT-1)/2 + 1 + (DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles after the line's falling edge (±1 for input phase). P = 1 when PARITY != 0, else 0.
- Reset mid-frame: abort immediately. Outputs clear to 0; no DV is produced for the partial frame.
- Illegal parameter values: stop elaboration via generate-time check.

Test Plan:
- CLKS_PER_BIT=16, defaults, send 0xA5 8N1 -> one o_Rx_DV pulse; o_Rx_Byte=0xA5; all three flags = 0; DV count = 1.
- DATA_BITS=7, PARITY=2, send 0x41 with correct even parity bit 0, then 0x41 with parity bit 1 -> first frame Parity_Err=0; second frame Parity_Err=1 and o_Rx_Byte=0x41.
- STOP_BITS=2, stop bits 1 then 0 -> o_Frame_Err=1 and o_Rx_DV pulses. Hold the line low 5 bit-times -> no further DV. Release, then send 0x3C -> o_Rx_Byte=0x3C, Frame_Err=0.
- Line held low 20 bit-times (8N1) -> exactly one DV with o_Rx_Byte=0x00, o_Break=1, o_Frame_Err=1; no DV until the line rises and a new frame arrives.
- Low glitch of 5 cycles (< (16-1)/2) -> no DV, outputs unchanged. Back-to-back frames 0x01, 0xFF, 0x80 with zero idle between them -> three DVs in order, correct bytes.
- Assert i_Rst_L low during data bit 4 of 0xF0 -> all outputs 0 asynchronously. Release, then send 0x5A -> single DV with 0x5A; the partial frame produces no DV.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional odd/even parity, 1-2 stop bits,
// with parity, framing and break status delivered alongside each received word.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $fatal(1, "uart_rx_cfg: illegal parameter value");
  end

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_C      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_C      = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT_C  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP_C = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PAR       = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic par_bit);
    logic x;
    x = (^data) ^ par_bit;
    if (PARITY == 1) begin
      parity_err_f = ~x;
    end else if (PARITY == 2) begin
      parity_err_f = x;
    end else begin
      parity_err_f = 1'b0;
    end
  endfunction

  logic                 r_sync1, r_sync2;
  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [3:0]           r_bit_idx, w_bit_idx_nxt;
  logic                 r_stop_idx, w_stop_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par_err, w_par_err_nxt;
  logic                 r_frame_err, w_frame_err_nxt;
  logic                 r_all_zero, w_all_zero_nxt;
  logic                 r_dv, w_dv_nxt;
  logic [DATA_BITS-1:0] r_byte, w_byte_nxt;
  logic                 r_perr_o, w_perr_o_nxt;
  logic                 r_ferr_o, w_ferr_o_nxt;
  logic                 r_brk_o, w_brk_o_nxt;
  logic                 w_rx;
  logic                 w_stop_ferr;
  logic                 w_stop_zero;

  assign w_rx = r_sync2;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_Rx_Serial;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver state, frame accumulators and registered outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 4'd0;
      r_stop_idx  <= 1'b0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_all_zero  <= 1'b0;
      r_dv        <= 1'b0;
      r_byte      <= '0;
      r_perr_o    <= 1'b0;
      r_ferr_o    <= 1'b0;
      r_brk_o     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_stop_idx  <= w_stop_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_par_err   <= w_par_err_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_all_zero  <= w_all_zero_nxt;
      r_dv        <= w_dv_nxt;
      r_byte      <= w_byte_nxt;
      r_perr_o    <= w_perr_o_nxt;
      r_ferr_o    <= w_ferr_o_nxt;
      r_brk_o     <= w_brk_o_nxt;
    end
  end

  assign w_stop_ferr = r_frame_err | ~w_rx;
  assign w_stop_zero = r_all_zero & ~w_rx;

  // Next-state and datapath logic; every sample point restarts the bit counter.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    w_bit_idx_nxt   = r_bit_idx;
    w_stop_idx_nxt  = r_stop_idx;
    w_shift_nxt     = r_shift;
    w_par_err_nxt   = r_par_err;
    w_frame_err_nxt = r_frame_err;
    w_all_zero_nxt  = r_all_zero;
    w_dv_nxt        = 1'b0;
    w_byte_nxt      = r_byte;
    w_perr_o_nxt    = r_perr_o;
    w_ferr_o_nxt    = r_ferr_o;
    w_brk_o_nxt     = r_brk_o;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt      = '0;
        w_bit_idx_nxt  = 4'd0;
        w_stop_idx_nxt = 1'b0;
        if (!w_rx) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == HALF_C) begin
          w_cnt_nxt = '0;
          if (!w_rx) begin
            w_state_nxt     = S_DATA;
            w_bit_idx_nxt   = 4'd0;
            w_stop_idx_nxt  = 1'b0;
            w_par_err_nxt   = 1'b0;
            w_frame_err_nxt = 1'b0;
            w_all_zero_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_C) begin
          w_cnt_nxt      = '0;
          w_shift_nxt    = {w_rx, r_shift[DATA_BITS-1:1]};
          w_all_zero_nxt = r_all_zero & ~w_rx;
          if (r_bit_idx == LAST_BIT_C) begin
            w_bit_idx_nxt = 4'd0;
            w_state_nxt   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PAR: begin
        if (r_cnt == FULL_C) begin
          w_cnt_nxt      = '0;
          w_par_err_nxt  = parity_err_f(r_shift, w_rx);
          w_all_zero_nxt = r_all_zero & ~w_rx;
          w_state_nxt    = S_STOP;
        end else begin
          w_state_nxt = S_PAR;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_C) begin
          w_cnt_nxt       = '0;
          w_frame_err_nxt = w_stop_ferr;
          w_all_zero_nxt  = w_stop_zero;
          if (r_stop_idx == LAST_STOP_C) begin
            // Outputs and the DV pulse load together on the edge after the last stop sample.
            w_stop_idx_nxt = 1'b0;
            w_dv_nxt       = 1'b1;
            w_byte_nxt     = r_shift;
            w_perr_o_nxt   = (PARITY != 0) ? r_par_err : 1'b0;
            w_ferr_o_nxt   = w_stop_ferr;
            w_brk_o_nxt    = w_stop_zero;
            w_state_nxt    = w_stop_ferr ? S_WAIT_HIGH : S_IDLE;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rx) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_Rx_DV      = r_dv;
  assign o_Rx_Byte    = r_byte;
  assign o_Parity_Err = r_perr_o;
  assign o_Frame_Err  = r_ferr_o;
  assign o_Break      = r_brk_o;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) at 16 clocks/bit.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] b;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic       dv_a, pe_a, fe_a, brk_a;
  logic [7:0] byte_a;
  logic       dv_b, pe_b, fe_b, brk_b;
  logic [6:0] byte_b;
  logic       dv_c, pe_c, fe_c, brk_c;
  logic [7:0] byte_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Break(brk_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Break(brk_b));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_c), .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c),
    .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Break(brk_c));

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [8:0] b, input logic pe, input logic fe, input logic brk);
    exp_t e;
    e = '{b: b, pe: pe, fe: fe, brk: brk};
    case (sel)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold(input int sel, input logic v, input int cycles);
    set_line(sel, v);
    repeat (cycles) @(negedge clk);
  endtask

  // Drives v[0] first, one bit-time per bit; the line is left at the last bit value.
  task automatic send_vec(input int sel, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      hold(sel, v[i], CPB);
    end
  endtask

  task automatic send_8n1(input int sel, input logic [7:0] b);
    send_vec(sel, {6'd0, 1'b1, b, 1'b0}, 10);
  endtask

  task automatic drain(input string nm);
    int left;
    for (int i = 0; i < 3000; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
      @(negedge clk);
    end
    left = q_a.size() + q_b.size() + q_c.size();
    chk(nm, 16'(left), 16'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_a"}, {4'd0, dv_a, pe_a, fe_a, brk_a, byte_a}, 16'd0);
    chk({nm, "_b"}, {5'd0, dv_b, pe_b, fe_b, brk_b, byte_b}, 16'd0);
    chk({nm, "_c"}, {4'd0, dv_c, pe_c, fe_c, brk_c, byte_c}, 16'd0);
  endtask

  // Monitor A: every DV must match the oldest queued expectation.
  always @(negedge clk) begin
    if (dv_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_dv", 16'd1, 16'd0);
      end else begin
        e_a = q_a.pop_front();
        chk("a_byte", 16'(byte_a), 16'(e_a.b));
        chk("a_perr", 16'(pe_a), 16'(e_a.pe));
        chk("a_ferr", 16'(fe_a), 16'(e_a.fe));
        chk("a_brk", 16'(brk_a), 16'(e_a.brk));
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (dv_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_dv", 16'd1, 16'd0);
      end else begin
        e_b = q_b.pop_front();
        chk("b_byte", 16'(byte_b), 16'(e_b.b));
        chk("b_perr", 16'(pe_b), 16'(e_b.pe));
        chk("b_ferr", 16'(fe_b), 16'(e_b.fe));
        chk("b_brk", 16'(brk_b), 16'(e_b.brk));
      end
    end
  end

  // Monitor C.
  always @(negedge clk) begin
    if (dv_c) begin
      if (q_c.size() == 0) begin
        chk("c_unexpected_dv", 16'd1, 16'd0);
      end else begin
        e_c = q_c.pop_front();
        chk("c_byte", 16'(byte_c), 16'(e_c.b));
        chk("c_perr", 16'(pe_c), 16'(e_c.pe));
        chk("c_ferr", 16'(fe_c), 16'(e_c.fe));
        chk("c_brk", 16'(brk_c), 16'(e_c.brk));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);

    // 8N1 basic frame
    push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send_8n1(0, 8'hA5);
    hold(0, 1'b1, 2 * CPB);
    drain("drain_a5");

    // 7E1: correct parity then wrong parity
    push(1, 9'h041, 1'b0, 1'b0, 1'b0);
    send_vec(1, {6'd0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
    push(1, 9'h041, 1'b1, 1'b0, 1'b0);
    send_vec(1, {6'd0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    hold(1, 1'b1, 2 * CPB);
    drain("drain_7e1");

    // 8N2: second stop bit low, line then held low, then a clean frame
    push(2, 9'h096, 1'b0, 1'b1, 1'b0);
    send_vec(2, {5'd0, 1'b0, 1'b1, 8'h96, 1'b0}, 11);
    hold(2, 1'b0, 5 * CPB);
    drain("drain_8n2_ferr");
    hold(2, 1'b1, 2 * CPB);
    push(2, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_vec(2, {5'd0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
    hold(2, 1'b1, 2 * CPB);
    drain("drain_8n2_ok");

    // Break: line low for 20 bit-times yields a single DV
    push(0, 9'h000, 1'b0, 1'b1, 1'b1);
    hold(0, 1'b0, 20 * CPB);
    drain("drain_break");
    hold(0, 1'b1, 2 * CPB);
    push(0, 9'h033, 1'b0, 1'b0, 1'b0);
    send_8n1(0, 8'h33);
    hold(0, 1'b1, 2 * CPB);
    drain("drain_after_break");

    // Back-to-back frames with no idle gap
    push(0, 9'h001, 1'b0, 1'b0, 1'b0);
    push(0, 9'h0FF, 1'b0, 1'b0, 1'b0);
    push(0, 9'h080, 1'b0, 1'b0, 1'b0);
    send_8n1(0, 8'h01);
    send_8n1(0, 8'hFF);
    send_8n1(0, 8'h80);
    hold(0, 1'b1, 2 * CPB);
    drain("drain_b2b");

    // Short low glitch is rejected as a false start
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 3 * CPB);
    chk("glitch_byte_held", 16'(byte_a), 16'h0080);
    chk("glitch_ferr_held", 16'(fe_a), 16'd0);

    // Reset during data bit 4 of 0xF0
    send_vec(0, 16'h0000, 5);
    hold(0, 1'b1, CPB / 2);
    rst_n = 1'b0;
    #1 chk_all_zero("midframe_reset");
    hold(0, 1'b1, 2 * CPB);
    rst_n = 1'b1;
    hold(0, 1'b1, 2 * CPB);
    push(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    send_8n1(0, 8'h5A);
    hold(0, 1'b1, 3 * CPB);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
